toy_mem_responder: RTL and testbench



---
 rtl/toy_mem_pkg.sv | 15 +
 rtl/toy_mem_if.sv | 25 ++
 rtl/toy_mem_array.sv | 47 ++++
 rtl/toy_mem_responder.sv | 106 ++++++++++
 tb/tb_toy_mem_responder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/toy_mem_pkg.sv
// Shared types and constants for the RISC_TOY memory responder.
package toy_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 30;

  localparam logic DRW_RD = 1'b0;
  localparam logic DRW_WR = 1'b1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/toy_mem_if.sv
// RISC_TOY instruction/data request bus; master = core, slave = memory.
interface toy_mem_if;
  import toy_mem_pkg::*;

  logic              IREQ;
  logic [ADDR_W-1:0] IADDR;
  logic [WORD_W-1:0] INSTR;
  logic              DREQ;
  logic              DRW;
  logic [ADDR_W-1:0] DADDR;
  logic [WORD_W-1:0] DWDATA;
  logic [WORD_W-1:0] DRDATA;
  logic              READY;
  logic              ERR;

  modport master (
    output IREQ, IADDR, DREQ, DRW, DADDR, DWDATA,
    input  INSTR, DRDATA, READY, ERR
  );

  modport slave (
    input  IREQ, IADDR, DREQ, DRW, DADDR, DWDATA,
    output INSTR, DRDATA, READY, ERR
  );
endinterface

// File: rtl/toy_mem_array.sv
// Word array with one write port and two registered read ports (fetch, load).
module toy_mem_array
  import toy_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WORD_W-1:0]     wdata,
  input  logic                  fetch_en,
  input  logic [DEPTH_LOG2-1:0] fetch_addr,
  input  logic                  fetch_zero,
  output logic [WORD_W-1:0]     fetch_data,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic                  load_zero,
  output logic [WORD_W-1:0]     load_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Fetch port forwards a same-cycle store so the core sees write-first data.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_data <= '0;
      load_data  <= '0;
    end else begin
      if (fetch_en) begin
        if (fetch_zero)                    fetch_data <= '0;
        else if (we && waddr == fetch_addr) fetch_data <= wdata;
        else                               fetch_data <= mem[fetch_addr];
      end
      if (load_en) begin
        load_data <= load_zero ? '0 : mem[load_addr];
      end
    end
  end

endmodule

// File: rtl/toy_mem_responder.sv
// Memory responder for RISC_TOY IREQ/DREQ ports with optional clear-after-reset.
// Optional feature: define TOY_MEM_BOUNDS_CHECK_EN for out-of-range detection on ERR.
module toy_mem_responder
  import toy_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2     = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic       CLK,
  input logic       RST,
  toy_mem_if.slave  bus
);

  localparam logic [DEPTH_LOG2-1:0] CNT_LAST = '1;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
  logic                  ready_q;

  logic                  clearing, run;
  logic [DEPTH_LOG2-1:0] i_idx, d_idx;
  logic                  i_oob, d_oob;
  logic                  we;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [WORD_W-1:0]     wdata;
  logic                  fetch_en, load_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // READY is registered so it stays low during reset even when clearing is skipped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == RUN);
    end
  end

  assign clearing = (state_q == CLEAR) && !RST;
  assign run      = (state_q == RUN) && !RST;
  assign i_idx    = bus.IADDR[DEPTH_LOG2-1:0];
  assign d_idx    = bus.DADDR[DEPTH_LOG2-1:0];

`ifdef TOY_MEM_BOUNDS_CHECK_EN
  logic err_q;

  assign i_oob = |(bus.IADDR >> DEPTH_LOG2);
  assign d_oob = |(bus.DADDR >> DEPTH_LOG2);

  always_ff @(posedge CLK) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= run && ((bus.IREQ && i_oob) || (bus.DREQ && d_oob));
  end

  assign bus.ERR = err_q;
`else
  // Upper address bits alias onto the array when bounds checking is off.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.IADDR[ADDR_W-1:DEPTH_LOG2], bus.DADDR[ADDR_W-1:DEPTH_LOG2]};
  assign i_oob   = 1'b0;
  assign d_oob   = 1'b0;
  assign bus.ERR = 1'b0;
`endif

  assign we       = clearing || (run && bus.DREQ && bus.DRW == DRW_WR && !d_oob);
  assign waddr    = clearing ? cnt_q : d_idx;
  assign wdata    = clearing ? '0 : bus.DWDATA;
  assign fetch_en = run && bus.IREQ;
  assign load_en  = run && bus.DREQ && bus.DRW == DRW_RD;

  toy_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk        (CLK),
    .rst        (RST),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .fetch_en   (fetch_en),
    .fetch_addr (i_idx),
    .fetch_zero (i_oob),
    .fetch_data (bus.INSTR),
    .load_en    (load_en),
    .load_addr  (d_idx),
    .load_zero  (d_oob),
    .load_data  (bus.DRDATA)
  );

  assign bus.READY = ready_q;

endmodule

// File: tb/tb_toy_mem_responder.sv
// Directed bench for toy_mem_responder: vector table plus reset/clear/bounds sequences.
module tb_toy_mem_responder;
  import toy_mem_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  toy_mem_if bus ();
  toy_mem_if bus0 ();

  toy_mem_responder #(
    .DEPTH_LOG2     (4),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  toy_mem_responder #(
    .DEPTH_LOG2     (4),
    .CLEAR_ON_RESET (1'b0)
  ) dut0 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus0)
  );

  typedef struct {
    logic        ireq;
    logic [29:0] iaddr;
    logic        dreq;
    logic        drw;
    logic [29:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] exp_instr;
    logic [31:0] exp_drdata;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ireq, input logic [29:0] iaddr, input logic dreq,
                       input logic drw, input logic [29:0] daddr, input logic [31:0] dwdata);
    bus.IREQ   = ireq;
    bus.IADDR  = iaddr;
    bus.DREQ   = dreq;
    bus.DRW    = drw;
    bus.DADDR  = daddr;
    bus.DWDATA = dwdata;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, DRW_RD, '0, '0);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int n;

    bus0.IREQ = 1'b0; bus0.IADDR = '0; bus0.DREQ = 1'b0;
    bus0.DRW = DRW_RD; bus0.DADDR = '0; bus0.DWDATA = '0;
    idle();

    // Reset values
    RST = 1'b1;
    step(); step();
    check("rst_instr",  bus.INSTR,  32'h0);
    check("rst_drdata", bus.DRDATA, 32'h0);
    check("rst_ready",  {31'h0, bus.READY}, 32'h0);
    check("rst_err",    {31'h0, bus.ERR},   32'h0);
    check("rst_ready_noclr", {31'h0, bus0.READY}, 32'h0);

    // Clear sequence; requests during clear must be ignored
    RST = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k >= 5 && k <= 15) drive(1'b1, 30'd2, 1'b1, DRW_WR, 30'd1, 32'h1111_1111);
      else idle();
      step();
      if (k == 1)  check("noclr_ready_first_edge", {31'h0, bus0.READY}, 32'h1);
      if (k == 15) begin
        check("clear_ready_low_15", {31'h0, bus.READY}, 32'h0);
        check("clear_instr_held",   bus.INSTR, 32'h0);
      end
      if (k == 16) check("clear_ready_16", {31'h0, bus.READY}, 32'h1);
    end
    drive(1'b1, 30'd5, 1'b1, DRW_RD, 30'd1, '0);
    step();
    check("fetch5_after_clear",   bus.INSTR,  32'h0);
    check("load1_ignored_store",  bus.DRDATA, 32'h0);

    // Table-driven RUN vectors
    vecs[0]  = '{1'b0, 30'd0,  1'b1, DRW_WR, 30'd3,  32'hDEAD_BEEF, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 30'd0,  1'b1, DRW_RD, 30'd3,  32'h0,         32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 30'd7,  1'b1, DRW_WR, 30'd7,  32'h1234_5678, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 30'd3,  1'b1, DRW_RD, 30'd7,  32'h0,         32'hDEAD_BEEF, 32'h1234_5678};
    vecs[4]  = '{1'b0, 30'd7,  1'b0, DRW_RD, 30'd0,  32'h0,         32'hDEAD_BEEF, 32'h1234_5678};
    vecs[5]  = '{1'b0, 30'd0,  1'b0, DRW_WR, 30'd3,  32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h1234_5678};
    vecs[6]  = '{1'b0, 30'd5,  1'b0, DRW_RD, 30'd7,  32'h0,         32'hDEAD_BEEF, 32'h1234_5678};
    vecs[7]  = '{1'b1, 30'd5,  1'b1, DRW_WR, 30'd5,  32'hCAFE_F00D, 32'hCAFE_F00D, 32'h1234_5678};
    vecs[8]  = '{1'b1, 30'd15, 1'b1, DRW_RD, 30'd0,  32'h0,         32'h0,         32'h0};
    vecs[9]  = '{1'b1, 30'd15, 1'b1, DRW_WR, 30'd15, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0};
    vecs[10] = '{1'b1, 30'd3,  1'b1, DRW_RD, 30'd15, 32'h0,         32'hDEAD_BEEF, 32'h0000_FFFF};

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].drw, vecs[i].daddr, vecs[i].dwdata);
      step();
      check($sformatf("vec%0d_instr", i),  bus.INSTR,  vecs[i].exp_instr);
      check($sformatf("vec%0d_drdata", i), bus.DRDATA, vecs[i].exp_drdata);
      check($sformatf("vec%0d_err", i),    {31'h0, bus.ERR}, 32'h0);
    end

    // Reset in RUN discards contents and restarts clearing
    drive(1'b0, '0, 1'b1, DRW_WR, 30'd2, 32'h0000_00AA);
    step();
    drive(1'b0, '0, 1'b1, DRW_RD, 30'd2, '0);
    step();
    check("load2_before_reset", bus.DRDATA, 32'h0000_00AA);
    idle();
    RST = 1'b1;
    step();
    check("midrst_ready",  {31'h0, bus.READY}, 32'h0);
    check("midrst_instr",  bus.INSTR,  32'h0);
    check("midrst_drdata", bus.DRDATA, 32'h0);
    RST = 1'b0;
    n = 0;
    while (!bus.READY && n < 40) begin
      step();
      n++;
    end
    check("midrst_clear_len", n, 32'd16);
    drive(1'b0, '0, 1'b1, DRW_RD, 30'd2, '0);
    step();
    check("load2_after_clear", bus.DRDATA, 32'h0);

    // Out-of-range addresses: aliasing or bounds check
    drive(1'b0, '0, 1'b1, DRW_WR, 30'd3, 32'h0000_0077);
    step();
    drive(1'b1, 30'h13, 1'b0, DRW_RD, '0, '0);
    step();
`ifdef TOY_MEM_BOUNDS_CHECK_EN
    check("oob_fetch_data", bus.INSTR, 32'h0);
    check("oob_fetch_err",  {31'h0, bus.ERR}, 32'h1);
`else
    check("alias_fetch_data", bus.INSTR, 32'h0000_0077);
    check("alias_fetch_err",  {31'h0, bus.ERR}, 32'h0);
`endif
    drive(1'b0, '0, 1'b1, DRW_WR, 30'h10, 32'h5A5A_5A5A);
    step();
`ifdef TOY_MEM_BOUNDS_CHECK_EN
    check("oob_store_err", {31'h0, bus.ERR}, 32'h1);
`else
    check("alias_store_err", {31'h0, bus.ERR}, 32'h0);
`endif
    idle();
    step();
    check("err_one_cycle", {31'h0, bus.ERR}, 32'h0);
    drive(1'b0, '0, 1'b1, DRW_RD, 30'd0, '0);
    step();
`ifdef TOY_MEM_BOUNDS_CHECK_EN
    check("oob_store_suppressed", bus.DRDATA, 32'h0);
`else
    check("alias_store_idx0", bus.DRDATA, 32'h5A5A_5A5A);
`endif
    drive(1'b0, '0, 1'b1, DRW_RD, 30'h23, '0);
    step();
`ifdef TOY_MEM_BOUNDS_CHECK_EN
    check("oob_load_zero", bus.DRDATA, 32'h0);
`else
    check("alias_load_idx3", bus.DRDATA, 32'h0000_0077);
`endif
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
